// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter with active-low one-hot grant and break-before-make gap.
// Optional forced release after TIMEOUT_CYCLES busy cycles when ARB_TIMEOUT_EN is defined.
module decoder_rr_arbiter #(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt_n,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] gap_cnt;
  logic [2:0] start;
  logic [7:0] rot;
  logic [2:0] pos;
  logic [2:0] win_idx;
  logic       win_any;
  logic       rel;
  logic       to_hit;

  // Rotate requests so bit 0 is the requester just after the last winner.
  always_comb begin
    start = ptr + 3'd1;
    for (int i = 0; i < 8; i++) rot[i] = req[start + 3'(i)];
    win_any = |rot;
    pos = '0;
    for (int i = 7; i >= 0; i--) if (rot[i]) pos = 3'(i);
    win_idx = start + pos;
  end

  assign rel = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [9:0] busy_cnt;
  assign to_hit = (busy_cnt == 10'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt_n   <= 8'hFF;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      ptr     <= 3'd7;
      gap_cnt <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      busy_cnt <= 10'd0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb_en && win_any) begin
            gnt_idx <= win_idx;
            gnt_n   <= ~(8'b1 << win_idx);
            gnt_vld <= 1'b1;
            state   <= BUSY;
`ifdef ARB_TIMEOUT_EN
            busy_cnt <= 10'd0;
`endif
          end
        end
        BUSY: begin
          if (rel || to_hit) begin
            gnt_n   <= 8'hFF;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx;
            gap_cnt <= 4'(GAP_CYCLES);
            state   <= GAP;
`ifdef ARB_TIMEOUT_EN
            // A normal release on the limit edge wins over the timeout.
            timeout <= !rel;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            busy_cnt <= busy_cnt + 10'd1;
          end
`endif
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
